// File: rtl/bcd_run_pkg.sv
// ==========================================================================
// bcd_run_pkg : shared states, digit geometry and BCD step for bcd_run_ctrl
// Revision 1.0
// ==========================================================================
`default_nettype none

package bcd_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  localparam int              DIGITS    = 4;
  localparam int              DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  // Value a decade digit takes after one increment.
  function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] d);
    return (d == DIGIT_MAX) ? '0 : d + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ==========================================================================
// bcd_digit : one decade (0-9) counter stage with clear and carry-out flag
// Revision 1.0
// ==========================================================================
`default_nettype none

module bcd_digit
  import bcd_run_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= digit_step(q);
    end
  end

  assign at_max = (q == DIGIT_MAX);

endmodule

`default_nettype wire

// File: rtl/bcd_run_ctrl.sv
// ==========================================================================
// bcd_run_ctrl : start/pause/clear sequencer for a 4-digit BCD counter chain
// Revision 1.0
// ==========================================================================
`default_nettype none

module bcd_run_ctrl
  import bcd_run_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic [DIGITS*DIGIT_W-1:0] limit,
  output logic [DIGITS*DIGIT_W-1:0] count,
  output logic                      running,
  output logic                      done,
  output logic                      tick
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  run_state_t                state_q;
  run_state_t                state_d;
  logic [PRE_W-1:0]          pre_q;
  logic [PRE_W-1:0]          pre_d;
  logic                      inc_fire;
  logic                      limit_hit;
  logic                      digit_clr;
  logic [DIGITS-1:0]         digit_max;
  logic [DIGITS-1:0]         digit_inc;
  logic [DIGITS*DIGIT_W-1:0] next_count;

  // A stop or clear on the terminal prescaler edge swallows the increment.
  assign inc_fire  = (state_q == RUN) && !clear && !stop && (pre_q == PRE_LAST);
  assign limit_hit = inc_fire && (next_count == limit);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] q;

    if (i == 0) begin : g_lsd
      assign digit_inc[i] = inc_fire;
    end else begin : g_carry
      assign digit_inc[i] = inc_fire & (&digit_max[i-1:0]);
    end

    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .clr    (digit_clr),
      .inc    (digit_inc[i]),
      .q      (q),
      .at_max (digit_max[i])
    );

    assign count[i*DIGIT_W +: DIGIT_W]      = q;
    assign next_count[i*DIGIT_W +: DIGIT_W] = digit_inc[i] ? digit_step(q) : q;
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    digit_clr = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      pre_d     = '0;
      digit_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
            if (limit_hit) begin
              state_d = DONE;
            end
          end
        end
        PAUSE: begin
          if (start && !stop) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (start) begin
            state_d   = RUN;
            pre_d     = '0;
            digit_clr = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      running <= (state_d == RUN);
      done    <= (state_d == DONE);
      tick    <= inc_fire;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_run_ctrl.sv
// ==========================================================================
// tb_bcd_run_ctrl : bench for bcd_run_ctrl at TICK_DIV = 4 and TICK_DIV = 1
// Revision 1.0
// ==========================================================================
`default_nettype none

module tb_bcd_run_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        reset, start, stop, clear;
  logic [15:0] limit;
  logic [15:0] count_a, count_b;
  logic        running_a, done_a, tick_a;
  logic        running_b, done_b, tick_b;

  int checks = 0;
  int errors = 0;

  int m_st[2];
  int m_ph[2];
  int m_cnt[2];
  bit m_tk[2];
  int div[2];

  always #5 clk = ~clk;

  bcd_run_ctrl #(.TICK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .limit(limit), .count(count_a), .running(running_a), .done(done_a), .tick(tick_a)
  );

  bcd_run_ctrl #(.TICK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .limit(limit), .count(count_b), .running(running_b), .done(done_b), .tick(tick_b)
  );

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  task automatic model_step(input int k);
    m_tk[k] = 1'b0;
    if (!reset) begin
      m_st[k] = M_IDLE; m_ph[k] = 0; m_cnt[k] = 0;
    end else if (clear) begin
      m_st[k] = M_IDLE; m_ph[k] = 0; m_cnt[k] = 0;
    end else begin
      case (m_st[k])
        M_IDLE:  if (start) begin m_st[k] = M_RUN; m_ph[k] = 0; end
        M_RUN: begin
          if (stop) m_st[k] = M_PAUSE;
          else if (m_ph[k] == div[k] - 1) begin
            m_cnt[k] = (m_cnt[k] + 1) % 10000;
            m_ph[k]  = 0;
            m_tk[k]  = 1'b1;
            if (to_bcd(m_cnt[k]) == limit) m_st[k] = M_DONE;
          end else m_ph[k] = m_ph[k] + 1;
        end
        M_PAUSE: if (start && !stop) m_st[k] = M_RUN;
        default: if (start) begin m_st[k] = M_RUN; m_ph[k] = 0; m_cnt[k] = 0; end
      endcase
    end
  endtask

  // One clock edge: both reference models advance on the same inputs.
  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); stop = 1'($urandom); clear = 1'($urandom);
      step();
    end
    start = 0; stop = 0; clear = 0;
    checks++;
    if ({count_a, running_a, done_a, tick_a} !== 19'h0) begin
      errors++; $display("FAIL reset_a got %h want 0", {count_a, running_a, done_a, tick_a});
    end
    checks++;
    if ({count_b, running_b, done_b, tick_b} !== 19'h0) begin
      errors++; $display("FAIL reset_b got %h want 0", {count_b, running_b, done_b, tick_b});
    end
    reset = 1'b1;
  endtask

  task automatic test_run_to_limit();
    limit = 16'h0012;
    start = 1; step(); start = 0;
    checks++;
    if (running_a !== 1'b1) begin
      errors++; $display("FAIL run_entry running got %b want 1", running_a);
    end
    repeat (47) step();
    checks++;
    if ({count_a, done_a} !== {16'h0011, 1'b0}) begin
      errors++; $display("FAIL pre_limit got %h/%b want 0011/0", count_a, done_a);
    end
    step();
    checks++;
    if ({count_a, running_a, done_a, tick_a} !== {16'h0012, 3'b011}) begin
      errors++; $display("FAIL limit_hit got %h %b%b%b want 0012 011", count_a, running_a, done_a, tick_a);
    end
    repeat (100) step();
    checks++;
    if ({count_a, running_a, done_a, tick_a} !== {16'h0012, 3'b010}) begin
      errors++; $display("FAIL done_hold got %h %b%b%b want 0012 010", count_a, running_a, done_a, tick_a);
    end
  endtask

  task automatic test_carry_wrap();
    clear = 1; step(); clear = 0;
    limit = 16'h00F0;
    start = 1; step(); start = 0;
    repeat (99) step();
    checks++;
    if (count_b !== 16'h0099) begin
      errors++; $display("FAIL carry_pre got %h want 0099", count_b);
    end
    step();
    checks++;
    if ({count_b, tick_b} !== {16'h0100, 1'b1}) begin
      errors++; $display("FAIL carry_0100 got %h/%b want 0100/1", count_b, tick_b);
    end
    repeat (9899) step();
    checks++;
    if (count_b !== 16'h9999) begin
      errors++; $display("FAIL reach_9999 got %h want 9999", count_b);
    end
    step();
    checks++;
    if ({count_b, running_b, done_b, tick_b} !== {16'h0000, 3'b101}) begin
      errors++; $display("FAIL wrap_nodone got %h %b%b%b want 0000 101", count_b, running_b, done_b, tick_b);
    end
    clear = 1; step(); clear = 0;
    limit = 16'h0000;
    start = 1; step(); start = 0;
    repeat (9999) step();
    checks++;
    if ({count_b, done_b} !== {16'h9999, 1'b0}) begin
      errors++; $display("FAIL lim0_early got %h/%b want 9999/0", count_b, done_b);
    end
    step();
    checks++;
    if ({count_b, running_b, done_b, tick_b} !== {16'h0000, 3'b011}) begin
      errors++; $display("FAIL lim0_done got %h %b%b%b want 0000 011", count_b, running_b, done_b, tick_b);
    end
  endtask

  task automatic test_pause_resume();
    clear = 1; step(); clear = 0;
    limit = 16'h9999;
    start = 1; step(); start = 0;
    repeat (22) step();
    checks++;
    if ({count_a, running_a} !== {16'h0005, 1'b1}) begin
      errors++; $display("FAIL pause_setup got %h/%b want 0005/1", count_a, running_a);
    end
    stop = 1; step(); stop = 0;
    repeat (20) step();
    checks++;
    if ({count_a, running_a, done_a} !== {16'h0005, 2'b00}) begin
      errors++; $display("FAIL pause_hold got %h %b%b want 0005 00", count_a, running_a, done_a);
    end
    start = 1; step(); start = 0;
    step();
    checks++;
    if ({count_a, running_a, tick_a} !== {16'h0005, 2'b10}) begin
      errors++; $display("FAIL resume_1 got %h %b%b want 0005 10", count_a, running_a, tick_a);
    end
    step();
    checks++;
    if ({count_a, tick_a} !== {16'h0006, 1'b1}) begin
      errors++; $display("FAIL resume_2 got %h/%b want 0006/1", count_a, tick_a);
    end
    repeat (3) step();
    stop = 1; step(); stop = 0;
    checks++;
    if ({count_a, running_a, tick_a} !== {16'h0006, 2'b00}) begin
      errors++; $display("FAIL stop_suppress got %h %b%b want 0006 00", count_a, running_a, tick_a);
    end
    start = 1; step(); start = 0;
    step();
    checks++;
    if ({count_a, tick_a} !== {16'h0007, 1'b1}) begin
      errors++; $display("FAIL resume_held_pre got %h/%b want 0007/1", count_a, tick_a);
    end
  endtask

  task automatic test_priorities();
    start = 1; stop = 1; step();
    checks++;
    if ({count_a, running_a, done_a} !== {16'h0007, 2'b00}) begin
      errors++; $display("FAIL startstop_run got %h %b%b want 0007 00", count_a, running_a, done_a);
    end
    step();
    checks++;
    if (running_a !== 1'b0) begin
      errors++; $display("FAIL startstop_pause running got %b want 0", running_a);
    end
    start = 0; stop = 0;
    clear = 1; step(); clear = 0;
    limit = 16'h0002;
    start = 1; step(); start = 0;
    repeat (8) step();
    checks++;
    if ({count_a, running_a, done_a, tick_a} !== {16'h0002, 3'b011}) begin
      errors++; $display("FAIL done_reach got %h %b%b%b want 0002 011", count_a, running_a, done_a, tick_a);
    end
    clear = 1; start = 1; step(); clear = 0; start = 0;
    checks++;
    if ({count_a, running_a, done_a, tick_a} !== {16'h0000, 3'b000}) begin
      errors++; $display("FAIL clear_start got %h %b%b%b want 0000 000", count_a, running_a, done_a, tick_a);
    end
    start = 1; step(); start = 0;
    repeat (8) step();
    start = 1; step(); start = 0;
    checks++;
    if ({count_a, running_a, done_a} !== {16'h0000, 2'b10}) begin
      errors++; $display("FAIL done_restart got %h %b%b want 0000 10", count_a, running_a, done_a);
    end
    repeat (4) step();
    checks++;
    if ({count_a, tick_a} !== {16'h0001, 1'b1}) begin
      errors++; $display("FAIL restart_count got %h/%b want 0001/1", count_a, tick_a);
    end
  endtask

  task automatic test_reset_mid_run();
    clear = 1; step(); clear = 0;
    limit = 16'h9999;
    start = 1; step(); start = 0;
    repeat (28) step();
    checks++;
    if (count_a !== 16'h0007) begin
      errors++; $display("FAIL midrun_setup got %h want 0007", count_a);
    end
    reset = 0; step(); reset = 1;
    checks++;
    if ({count_a, running_a, done_a, tick_a} !== 19'h0) begin
      errors++; $display("FAIL midrun_reset got %h want 0", {count_a, running_a, done_a, tick_a});
    end
    start = 1; step(); start = 0;
    repeat (4) step();
    checks++;
    if ({count_a, running_a} !== {16'h0001, 1'b1}) begin
      errors++; $display("FAIL after_reset got %h/%b want 0001/1", count_a, running_a);
    end
  endtask

  task automatic test_random();
    logic [18:0] exp;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) != 0);
      clear = ($urandom_range(0, 49) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 31) == 0)
        limit = ($urandom_range(0, 3) == 0) ? 16'($urandom) : to_bcd(int'($urandom_range(0, 30)));
      step();
      exp = {to_bcd(m_cnt[0]), m_st[0] == M_RUN, m_st[0] == M_DONE, m_tk[0]};
      checks++;
      if ({count_a, running_a, done_a, tick_a} !== exp) begin
        errors++; $display("FAIL rand_a cyc %0d got %h want %h", c, {count_a, running_a, done_a, tick_a}, exp);
      end
      exp = {to_bcd(m_cnt[1]), m_st[1] == M_RUN, m_st[1] == M_DONE, m_tk[1]};
      checks++;
      if ({count_b, running_b, done_b, tick_b} !== exp) begin
        errors++; $display("FAIL rand_b cyc %0d got %h want %h", c, {count_b, running_b, done_b, tick_b}, exp);
      end
    end
  endtask

  initial begin
    div[0] = 4; div[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE; m_ph[k] = 0; m_cnt[k] = 0; m_tk[k] = 1'b0;
    end
    reset = 0; start = 0; stop = 0; clear = 0; limit = 16'h0000;
    test_reset();
    test_run_to_limit();
    test_carry_wrap();
    test_pause_resume();
    test_priorities();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_run_ctrl.md
# bcd_run_ctrl

Sequencing controller for a 4-digit chain of decade (BCD 0–9) counters. A prescaler turns `clk` into count ticks, and a small FSM starts, pauses, resumes and clears the chain on command pulses. A BCD limit compare stops the chain automatically. The block sits between the user push-button/command logic and the display driver, which reads `count`.

## Interface
Parameters:
- `TICK_DIV`, default 4: `clk` cycles per count increment while running; legal range ≥1.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `start`  in  1  command: run or resume; sampled each edge.
- `stop`  in  1  command: pause; sampled each edge.
- `clear`  in  1  command: return to idle and zero the count.
- `limit`  in  16  BCD target, digit 3 in [15:12] … digit 0 in [3:0].
- `count`  out  16  BCD count, same digit layout as `limit`; registered.
- `running`  out  1  1 while the FSM is in RUN; registered.
- `done`  out  1  1 while the FSM is in DONE; registered.
- `tick`  out  1  one-cycle pulse, high in the first cycle `count` shows a new value; registered.

## Operation
- FSM states: IDLE, RUN, PAUSE, DONE.
- Command priority: `reset` > `clear` > `stop` > `start`.
- `clear` in any state → IDLE; `count` = 0000; prescaler = 0.
- IDLE: `start` → RUN with the prescaler at 0. `stop` is ignored.
- RUN:
  - Prescaler counts 0…TICK_DIV-1.
  - At the edge where prescaler = TICK_DIV-1 and there is no `stop`/`clear`: `count` increments, prescaler returns to 0, and `tick` = 1 next cycle.
  - `stop` → PAUSE. The prescaler value and `count` are held, and the increment due on that edge is suppressed.
  - If the incremented value equals `limit` → DONE on the same edge.
  - `start` in RUN has no effect.
- PAUSE: `start` → RUN with the prescaler resuming from its held value.
- DONE: `count` is held. `start` → RUN from `count` = 0000, prescaler 0. `stop` is ignored.
- Increment rule, per digit i: increments when the tick occurs and all lower digits = 9. A digit at 9 wraps to 0. 9999 → 0000 is a normal increment.
- Limit compare: only the post-increment value is compared, so `limit` = 0000 is reached only on the 9999 → 0000 wrap. A `limit` containing any digit >9 never matches, and the chain wraps forever.
- `limit` may change at any time; the compare uses the value present at the increment edge.
- Invalid BCD values never appear on `count`.

## Timing
- Reset values: `count` = 0000, `running` = 0, `done` = 0, `tick` = 0, state IDLE, prescaler 0.
- `start` high at edge n in IDLE: `running` = 1 from cycle n+1.
- First increment occurs at edge n+TICK_DIV, with `tick` = 1 during cycle n+TICK_DIV+1.
- TICK_DIV = 1: one increment per RUN cycle; `tick` stays high continuously while running.
- Reaching the limit: `done` = 1 and `running` = 0 in the same cycle that `tick` = 1 and `count` = `limit`.
- Simultaneous events:
  - `start`+`stop` in RUN → PAUSE.
  - `start`+`stop` in PAUSE → stays PAUSE.
  - `clear` with any other input → IDLE.
- Reset mid-operation overrides everything at the next edge.

## Structure
- Shared package `bcd_run_pkg`:
  - state enum `run_state_t` {IDLE, RUN, PAUSE, DONE};
  - `DIGITS` = 4, `DIGIT_W` = 4, `DIGIT_MAX` = 4'd9.
- Sub-module `bcd_digit`, instantiated 4× in a carry chain:
  - inputs: `clk`, `reset`, `clr`, `inc`;
  - outputs: `q[3:0]`, `at_max` (q = 9);
  - behaviour: wraps 9 → 0 on `inc`.
- Top level holds the FSM, the prescaler ($clog2(TICK_DIV) bits, minimum 1), the limit compare and the registered `tick`.

## Test plan
All scenarios use TICK_DIV = 4 unless stated.
- Reset: hold `reset` = 0 for 2 cycles, with commands toggling → `count` 0000, `running`/`done`/`tick` all 0.
- Run to limit: `limit` = 0012, `start` pulse at edge n → `count` = 0012 with `done` = 1 at cycle n+49. `count` is still 0012 100 cycles later.
- Carry/wrap (TICK_DIV = 1):
  - `limit` = 00F0 (never matches): step 0099 → 0100 in one tick, and 9999 → 0000 with no `done`.
  - `limit` = 0000: `done` after exactly 10000 ticks.
- Pause/resume: `stop` asserted with `count` = 0005 and prescaler = 2 → PAUSE and the count holds for 20 cycles. Then `start` → RUN, and `count` = 0006 is visible 2 cycles after RUN entry.
- Priorities:
  - `start`+`stop` in RUN → PAUSE.
  - `clear`+`start` in DONE → IDLE, `count` 0000.
  - `start` in DONE → RUN, restarting from 0000.
- Reset mid-run: `reset` = 0 at `count` = 0007 → all outputs return to reset values the next cycle. A subsequent `start` counts from 0000.
